// File: rtl/risc_pkg.sv
// Shared definitions for the fetch front end: datapath width, NOP encoding,
// fetch FSM states and the PC increment.
package risc_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_INC = 32'd4;

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry skid register that holds a fetched instruction and its PC+4
// while decode is stalled. Flush has priority over load and drain.
module fetch_skid_buf
  import risc_pkg::*;
#(
  parameter logic [XLEN-1:0] NOP_INSTR = INSTR_NOP
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_load,
  input  logic            i_drain,
  input  logic            i_flush,
  input  logic [XLEN-1:0] i_instr,
  input  logic [XLEN-1:0] i_pc_plus4,
  output logic [XLEN-1:0] o_instr,
  output logic [XLEN-1:0] o_pc_plus4,
  output logic            o_full
);

  logic [XLEN-1:0] r_instr;
  logic [XLEN-1:0] r_pc_plus4;
  logic            r_full;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_instr    <= NOP_INSTR;
      r_pc_plus4 <= '0;
      r_full     <= 1'b0;
    end else if (i_flush) begin
      r_full <= 1'b0;
    end else if (i_load) begin
      r_instr    <= i_instr;
      r_pc_plus4 <= i_pc_plus4;
      r_full     <= 1'b1;
    end else if (i_drain) begin
      r_full <= 1'b0;
    end
  end

  assign o_instr    = r_instr;
  assign o_pc_plus4 = r_pc_plus4;
  assign o_full     = r_full;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID register and one-entry skid buffer.
// Optional performance counters are enabled with FETCH_PERF_CNT_EN.
module fetch_stage
  import risc_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [XLEN-1:0] NOP_INSTR = INSTR_NOP
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            imem_ready,
  input  logic            stall_id,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  output logic            id_valid,
  output logic [XLEN-1:0] id_instr,
  output logic [XLEN-1:0] id_pc_plus4
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [XLEN-1:0] perf_fetched,
  output logic [XLEN-1:0] perf_stall_cyc
`endif
);

  fetch_state_t    r_state;
  logic [XLEN-1:0] r_pc;
  logic            r_req;
  logic            r_id_valid;
  logic [XLEN-1:0] r_id_instr;
  logic [XLEN-1:0] r_id_pc_plus4;

  logic            w_fire;
  logic            w_slot_free;
  logic [XLEN-1:0] w_pc_next;
  logic [XLEN-1:0] w_redirect_pc;
  logic            w_skid_load;
  logic            w_skid_drain;
  logic [XLEN-1:0] w_skid_instr;
  logic [XLEN-1:0] w_skid_pc_plus4;
  logic            w_skid_full;

  // A fetch only completes when a request was actually outstanding.
  assign w_fire        = (r_state == FETCH) && r_req && imem_ready;
  assign w_slot_free   = !r_id_valid || !stall_id;
  assign w_pc_next     = r_pc + PC_INC;
  assign w_redirect_pc = redirect_target & ~32'h0000_0003;
  assign w_skid_load   = !redirect_valid && w_fire && !w_slot_free;
  assign w_skid_drain  = !redirect_valid && (r_state == HOLD) && !stall_id;

  fetch_skid_buf #(
    .NOP_INSTR(NOP_INSTR)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_skid_load),
    .i_drain   (w_skid_drain),
    .i_flush   (redirect_valid),
    .i_instr   (imem_rdata),
    .i_pc_plus4(w_pc_next),
    .o_instr   (w_skid_instr),
    .o_pc_plus4(w_skid_pc_plus4),
    .o_full    (w_skid_full)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state       <= FETCH;
      r_pc          <= RESET_PC;
      r_req         <= 1'b0;
      r_id_valid    <= 1'b0;
      r_id_instr    <= NOP_INSTR;
      r_id_pc_plus4 <= '0;
    end else if (redirect_valid) begin
      // Redirect wins over stall and drops any response arriving this cycle.
      r_state    <= FETCH;
      r_pc       <= w_redirect_pc;
      r_req      <= 1'b1;
      r_id_valid <= 1'b0;
      r_id_instr <= NOP_INSTR;
    end else begin
      case (r_state)
        FETCH: begin
          r_req <= 1'b1;
          if (w_fire && w_slot_free) begin
            r_id_valid    <= 1'b1;
            r_id_instr    <= imem_rdata;
            r_id_pc_plus4 <= w_pc_next;
            r_pc          <= w_pc_next;
          end else if (w_fire) begin
            r_pc    <= w_pc_next;
            r_state <= HOLD;
            r_req   <= 1'b0;
          end else if (!stall_id) begin
            r_id_valid <= 1'b0;
            r_id_instr <= NOP_INSTR;
          end
        end
        HOLD: begin
          if (!stall_id) begin
            r_id_valid    <= w_skid_full;
            r_id_instr    <= w_skid_instr;
            r_id_pc_plus4 <= w_skid_pc_plus4;
            r_state       <= FETCH;
            r_req         <= 1'b1;
          end
        end
        default: r_state <= FETCH;
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [XLEN-1:0] r_perf_fetched;
  logic [XLEN-1:0] r_perf_stall_cyc;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_perf_fetched   <= '0;
      r_perf_stall_cyc <= '0;
    end else begin
      if (w_fire && !redirect_valid)
        r_perf_fetched <= r_perf_fetched + 32'd1;
      if (r_id_valid && stall_id)
        r_perf_stall_cyc <= r_perf_stall_cyc + 32'd1;
    end
  end

  assign perf_fetched   = r_perf_fetched;
  assign perf_stall_cyc = r_perf_stall_cyc;
`endif

  assign imem_req    = r_req;
  assign imem_addr   = r_pc;
  assign id_valid    = r_id_valid;
  assign id_instr    = r_id_instr;
  assign id_pc_plus4 = r_id_pc_plus4;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage; memory returns word = address.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic        stall_id;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc_plus4;

  int checks = 0;
  int errors = 0;

  fetch_stage dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .imem_ready     (imem_ready),
    .stall_id       (stall_id),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .id_valid       (id_valid),
    .id_instr       (id_instr),
    .id_pc_plus4    (id_pc_plus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign imem_rdata = imem_ready ? imem_addr : 32'hDEAD_BEEF;

  task automatic applyStimulus(input logic nRst, input logic ready, input logic stall,
                               input logic redir, input logic [31:0] target);
    rst             = nRst;
    imem_ready      = ready;
    stall_id        = stall;
    redirect_valid  = redir;
    redirect_target = target;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic checkId(input string tag, input logic valid, input logic [31:0] instr,
                         input logic [31:0] pc4);
    checkOutput({tag, ".id_valid"}, {31'd0, id_valid}, {31'd0, valid});
    checkOutput({tag, ".id_instr"}, id_instr, instr);
    checkOutput({tag, ".id_pc_plus4"}, id_pc_plus4, pc4);
  endtask

  initial begin
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    tick();
    tick();
    $display("[TB] reset state");
    checkId("reset", 1'b0, 32'h0, 32'h0);
    checkOutput("reset.imem_req", {31'd0, imem_req}, 32'd0);
    checkOutput("reset.imem_addr", imem_addr, 32'h0);

    // Release reset: first edge raises imem_req, then one instruction per clock.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    tick();
    checkOutput("start.imem_req", {31'd0, imem_req}, 32'd1);
    checkOutput("start.imem_addr", imem_addr, 32'h0);
    checkOutput("start.id_valid", {31'd0, id_valid}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      checkId("stream", 1'b1, 32'(4 * k), 32'(4 * k + 4));
    end
    checkOutput("stream.imem_addr", imem_addr, 32'h10);

    $display("[TB] wait states at address 8");
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 32'h8);
    tick();
    checkOutput("redir8.imem_addr", imem_addr, 32'h8);
    checkOutput("redir8.id_valid", {31'd0, id_valid}, 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    for (int k = 0; k < 3; k++) begin
      tick();
      checkOutput("wait.imem_addr", imem_addr, 32'h8);
      checkOutput("wait.id_valid", {31'd0, id_valid}, 32'd0);
    end
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    tick();
    checkId("waitdone", 1'b1, 32'h8, 32'hC);

    $display("[TB] decode stall with skid");
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 32'h4);
    tick();
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    tick();
    checkId("pre_stall", 1'b1, 32'h4, 32'h8);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    for (int k = 0; k < 2; k++) begin
      tick();
      checkId("stall", 1'b1, 32'h4, 32'h8);
      checkOutput("stall.imem_req", {31'd0, imem_req}, 32'd0);
    end
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    tick();
    checkId("drain", 1'b1, 32'h8, 32'hC);
    checkOutput("drain.imem_req", {31'd0, imem_req}, 32'd1);
    checkOutput("drain.imem_addr", imem_addr, 32'hC);
    tick();
    checkId("after_drain", 1'b1, 32'hC, 32'h10);

    $display("[TB] redirect during stall with full skid");
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    tick();
    checkOutput("hold2.imem_req", {31'd0, imem_req}, 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0103);
    tick();
    checkId("flush", 1'b0, 32'h0, 32'h10);
    checkOutput("flush.imem_addr", imem_addr, 32'h100);
    checkOutput("flush.imem_req", {31'd0, imem_req}, 32'd1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    tick();
    checkId("target", 1'b1, 32'h100, 32'h104);
    tick();
    checkId("skid_empty", 1'b1, 32'h104, 32'h108);

    $display("[TB] reset while holding");
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    tick();
    checkOutput("hold3.imem_req", {31'd0, imem_req}, 32'd0);
    checkOutput("hold3.id_instr", id_instr, 32'h104);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    tick();
    checkId("rst_hold", 1'b0, 32'h0, 32'h0);
    checkOutput("rst_hold.imem_req", {31'd0, imem_req}, 32'd0);
    checkOutput("rst_hold.imem_addr", imem_addr, 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    tick();
    checkOutput("restart.imem_req", {31'd0, imem_req}, 32'd1);
    tick();
    checkId("restart", 1'b1, 32'h0, 32'h4);

    $display("[TB] pc wrap");
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
    tick();
    checkOutput("wrap.imem_addr", imem_addr, 32'hFFFF_FFFC);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    tick();
    checkId("wrap_top", 1'b1, 32'hFFFF_FFFC, 32'h0);
    checkOutput("wrap_next.imem_addr", imem_addr, 32'h0);
    tick();
    checkId("wrap_zero", 1'b1, 32'h0, 32'h4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
